instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream fetch stage for the MIPS datapath. Owns the fetch PC, issues word reads to a
//  variable-latency instruction memory over a req/ack handshake, and buffers returned words
//  with their PCs in a small prefetch FIFO. Delivers {Inst, Inst_PC} to decode/execute over a
//  valid/ready handshake. Accepts branch/jump redirects from the datapath and flushes stale work.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset (word aligned)
//  FIFO_DEPTH  4              prefetch entries; power of 2, >= 2
// PORTS
//  Clk          in   1   single clock, all state on posedge
//  Reset        in   1   synchronous, active-high
//  Mem_Req      out  1   read request to instruction memory
//  Mem_Addr     out  32  byte address of request (= fetch PC), stable while Mem_Req high
//  Mem_Ack      in   1   request completed this cycle; Mem_Rdata valid this cycle
//  Mem_Rdata    in   32  instruction word
//  Redirect     in   1   taken branch/jump: discard all fetched/in-flight work
//  Redirect_PC  in   32  new fetch address; bits [1:0] forced to 0
//  Inst_Valid   out  1   FIFO head valid
//  Inst         out  32  FIFO head instruction
//  Inst_PC      out  32  FIFO head PC
//  Inst_Ready   in   1   consumer takes head when Inst_Valid & Inst_Ready
// BEHAVIOUR
//  Reset: Fetch_PC=RESET_PC, FIFO empty, state IDLE; Mem_Req=0, Inst_Valid=0, Inst=0, Inst_PC=0.
//   Reset overrides every event, including an outstanding request (memory shares Reset).
//  FSM states: IDLE (Mem_Req=0), REQ (Mem_Req=1), DISCARD (Mem_Req=1, response dropped).
//   Mem_Req = (state!=IDLE); Mem_Addr = Fetch_PC in REQ, held old address in DISCARD.
//  Credit: at most one request outstanding; request only when count_next < FIFO_DEPTH, where
//   count_next includes this cycle's push/pop. FIFO never overflows; no push ever dropped.
//  IDLE -> REQ when credit available. REQ + Mem_Ack: push {Mem_Rdata, Fetch_PC},
//   Fetch_PC += 4 (mod 2^32, wraps FFFF_FFFC -> 0); stay REQ if credit remains, else IDLE.
//   Mem_Ack may arrive in the first Req cycle (zero-wait) -> one fetch per cycle sustained.
//  Redirect (priority over push/pop): FIFO flushed (Inst_Valid=0 next cycle), Fetch_PC <= 
//   {Redirect_PC[31:2],2'b00}. If REQ without Mem_Ack this cycle -> DISCARD (request not
//   withdrawn). If Mem_Ack same cycle -> data dropped, next state REQ at new PC. IDLE -> REQ.
//  DISCARD + Mem_Ack: drop data, -> REQ at new PC. Redirect in DISCARD: update Fetch_PC only.
//  Latency: Mem_Ack in cycle n -> Inst_Valid/Inst/Inst_PC at cycle n+1; no bypass.
//  Pop and push same cycle legal (count unchanged). Pop while empty ignored.
//  Inst/Inst_PC hold value while Inst_Valid & ~Inst_Ready; undefined-free (last value) when empty.
//  Mem_Ack outside REQ/DISCARD is a protocol error: ignored; flagged by bench assertion.
// STRUCTURE
//  Shared header (fetch_defines): state encodings IDLE/REQ/DISCARD, WORD_BYTES=4,
//   FIFO entry width 64 ({PC,Inst}) and field offsets.
//  Sub-module fetch_fifo: sync FIFO, DEPTH param, push/pop/flush, count, wrapping ptrs
//   (log2 DEPTH + 1 bit for full/empty). Top holds FSM, Fetch_PC, credit logic.
// TESTING
//  1 Reset, Mem_Ack=Mem_Req (zero-wait), Inst_Ready=1 -> Mem_Addr 0,4,8,..; Inst_PC=0 one
//    cycle after first ack, then one instruction per cycle, Inst matches memory image.
//  2 Inst_Ready=0, DEPTH=4 -> exactly 4 acks then Mem_Req=0, head PC=0 held; one pop ->
//    exactly one new request at Mem_Addr=0x10.
//  3 Ack latency 3, Redirect to 0x100 one cycle into request at 0x8 -> Mem_Addr stays 0x8
//    until ack, that word never appears, next Mem_Addr=0x100, first Inst_PC=0x100.
//  4 FIFO holding 2 entries, Redirect_PC=0x203 with Mem_Ack same cycle -> next cycle
//    Inst_Valid=0, Mem_Addr=0x200; no stale PC ever delivered.
//  5 RESET_PC=32'hFFFF_FFF8 -> Mem_Addr FFFF_FFF8, FFFF_FFFC, 0000_0000; Inst_PC in order.
//  6 Reset asserted while DISCARD with 3 FIFO entries -> next cycle Mem_Req=0,
//    Inst_Valid=0, Inst=0, Inst_PC=0; after release first Mem_Addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// fetch-word geometry and the layout of a prefetch FIFO entry.
package instruction_fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam int WORD_BYTES = 4;

  // One prefetch entry is {PC, instruction}.
  localparam int ENTRY_W  = 64;
  localparam int INST_LSB = 0;
  localparam int PC_LSB   = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, wrapping pointers with one
// extra bit to tell full from empty. Flush empties it in one cycle. When empty
// the output shows the last entry that left the head, never stale storage.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] last_q;
  logic             empty;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign valid_o = ~empty;
  assign pop_ok  = pop_i & ~empty;
  assign data_o  = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and head-history update; flush wins over push/pop.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= data_o;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= data_o;
      end
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; it is only read while the pointers say it holds written data.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one outstanding word read at a time
// to instruction memory, buffers returned words with their PCs and hands them
// to decode. A redirect flushes buffered work and drops any in-flight reply.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Inst_Valid,
  output logic [31:0] Inst,
  output logic [31:0] Inst_PC,
  input  logic        Inst_Ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_addr_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   count_next;
  logic          push, pop, credit;
  fetch_entry_t  push_entry, head;
  logic [ENTRY_W-1:0] head_bits;

  // A reply is only kept when it answers a live request and no redirect kills it.
  assign push = (state_q == ST_REQ) & Mem_Ack & ~Redirect;
  assign pop  = Inst_Valid & Inst_Ready;

  // Occupancy after this cycle; a new request is allowed only if its reply will fit.
  assign count_next = Redirect ? '0
                    : {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign credit     = (count_next < DEPTH_C);

  assign push_entry = '{pc: fetch_pc_q, inst: Mem_Rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (Redirect),
    .data_o  (head_bits),
    .valid_o (Inst_Valid),
    .count_o (fifo_count)
  );

  assign head    = fetch_entry_t'(head_bits);
  assign Inst    = head.inst;
  assign Inst_PC = head.pc;

  // The in-flight address must stay put in DISCARD even though Fetch_PC moved on.
  assign Mem_Req  = (state_q != ST_IDLE);
  assign Mem_Addr = (state_q == ST_DISCARD) ? hold_addr_q : fetch_pc_q;

  // Next-state and next-PC selection; a redirect overrides the PC in every state.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (credit) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (Redirect) begin
          state_d = Mem_Ack ? ST_REQ : ST_DISCARD;
        end else if (Mem_Ack) begin
          state_d    = credit ? ST_REQ : ST_IDLE;
          fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
        end
      end
      ST_DISCARD: begin
        if (Mem_Ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (Redirect) fetch_pc_d = word_align(Redirect_PC);
  end

  // FSM, fetch PC and captured request address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (state_q == ST_REQ) hold_addr_q <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: zero-wait streaming, backpressure
// credit, redirect during a slow request, redirect with a same-cycle reply,
// PC wrap at the top of memory, and reset in the middle of activity.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_Req, Mem_Ack;
  logic [31:0] Mem_Addr, Mem_Rdata;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Inst_Valid, Inst_Ready;
  logic [31:0] Inst, Inst_PC;

  logic        hi_req, hi_ack, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_inst, hi_pc;
  logic        hi_ready, hi_redirect;
  logic [31:0] hi_redirect_pc;

  int tests = 0;
  int fails = 0;
  int mem_lat;
  logic [3:0] wc;

  always #5 Clk = ~Clk;

  // Memory image: a fixed scramble of the address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .Inst_Valid(Inst_Valid), .Inst(Inst),
    .Inst_PC(Inst_PC), .Inst_Ready(Inst_Ready)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_hi (
    .Clk(Clk), .Reset(Reset), .Mem_Req(hi_req), .Mem_Addr(hi_addr),
    .Mem_Ack(hi_ack), .Mem_Rdata(hi_rdata), .Redirect(hi_redirect),
    .Redirect_PC(hi_redirect_pc), .Inst_Valid(hi_valid), .Inst(hi_inst),
    .Inst_PC(hi_pc), .Inst_Ready(hi_ready)
  );

  // Memory responder: acknowledges after mem_lat wait cycles.
  always @(posedge Clk) begin
    if (Reset || !Mem_Req || Mem_Ack) wc <= 4'd0;
    else                              wc <= wc + 4'd1;
  end
  always_comb begin
    Mem_Ack   = Mem_Req && (int'(wc) >= mem_lat);
    Mem_Rdata = img(Mem_Addr);
    hi_ack    = hi_req;
    hi_rdata  = img(hi_addr);
  end
  assign hi_ready       = 1'b1;
  assign hi_redirect    = 1'b0;
  assign hi_redirect_pc = 32'h0;

  // Protocol: an ack without a live request is a responder error.
  always @(negedge Clk) begin
    if (Reset === 1'b0)
      assert (!(Mem_Ack && !Mem_Req)) else begin
        fails++;
        $error("FAIL proto_ack: observed ack=%b req=%b required no ack without req", Mem_Ack, Mem_Req);
      end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  int  acks;
  logic found;

  initial begin
    Reset = 1'b1; Redirect = 1'b0; Redirect_PC = 32'h0;
    Inst_Ready = 1'b1; mem_lat = 0;

    // 1: reset state, then zero-wait streaming
    do_reset();
    check("rst_req",   Mem_Req,    32'd0);
    check("rst_valid", Inst_Valid, 32'd0);
    check("rst_inst",  Inst,       32'd0);
    check("rst_pc",    Inst_PC,    32'd0);
    tick();
    check("t1_addr0",   Mem_Addr,   32'h0);
    check("t1_ack0",    Mem_Ack,    32'd1);
    check("t1_novalid", Inst_Valid, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_valid", Inst_Valid, 32'd1);
      check("t1_pc",    Inst_PC,    32'(4 * i));
      check("t1_inst",  Inst,       img(32'(4 * i)));
      check("t1_addr",  Mem_Addr,   32'(4 * (i + 1)));
    end

    // 2: backpressure, credit stops at depth, one pop buys one request
    Inst_Ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (Mem_Ack) acks++;
      tick();
    end
    check("t2_acks4",  32'(acks),  32'd4);
    check("t2_idle",   Mem_Req,    32'd0);
    check("t2_hvalid", Inst_Valid, 32'd1);
    check("t2_hpc",    Inst_PC,    32'h0);
    check("t2_hinst",  Inst,       img(32'h0));
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
    check("t2_rereq",  Mem_Req,  32'd1);
    check("t2_addr10", Mem_Addr, 32'h10);
    check("t2_popped", Inst_PC,  32'h4);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (Mem_Ack) acks++;
      tick();
    end
    check("t2_acks1", 32'(acks), 32'd1);
    check("t2_idle2", Mem_Req,   32'd0);

    // 3: slow memory, redirect one cycle into the request at 0x8
    mem_lat = 3; Inst_Ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (Mem_Req && Mem_Addr == 32'h8) found = 1'b1;
      else tick();
    end
    check("t3_reach8", 32'(found), 32'd1);
    tick();
    check("t3_noack", Mem_Ack, 32'd0);
    Redirect = 1'b1; Redirect_PC = 32'h100;
    tick();
    Redirect = 1'b0;
    check("t3_dhold",  Mem_Addr,   32'h8);
    check("t3_dreq",   Mem_Req,    32'd1);
    check("t3_flush",  Inst_Valid, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      check("t3_hold8", Mem_Addr, 32'h8);
      if (Mem_Ack) found = 1'b1;
      else tick();
    end
    check("t3_acked", 32'(found), 32'd1);
    tick();
    check("t3_new",    Mem_Addr,   32'h100);
    check("t3_nov",    Inst_Valid, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (Inst_Valid) found = 1'b1;
      else tick();
    end
    check("t3_gotv",  32'(found), 32'd1);
    check("t3_pc100", Inst_PC,    32'h100);
    check("t3_inst",  Inst,       img(32'h100));

    // 4: redirect with reply in the same cycle while two entries are buffered
    mem_lat = 0; Inst_Ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("t4_pre_v",   Inst_Valid, 32'd1);
    check("t4_pre_pc",  Inst_PC,    32'h0);
    check("t4_pre_a",   Mem_Addr,   32'h8);
    check("t4_pre_ack", Mem_Ack,    32'd1);
    Redirect = 1'b1; Redirect_PC = 32'h203;
    tick();
    Redirect = 1'b0;
    check("t4_flush", Inst_Valid, 32'd0);
    check("t4_addr",  Mem_Addr,   32'h200);
    check("t4_req",   Mem_Req,    32'd1);
    Inst_Ready = 1'b1;
    tick();
    check("t4_v1",  Inst_Valid, 32'd1);
    check("t4_pc1", Inst_PC,    32'h200);
    tick();
    check("t4_pc2", Inst_PC,    32'h204);

    // 5: PC wrap at the top of the address space
    do_reset();
    tick();
    check("t5_a0",  hi_addr, 32'hFFFF_FFF8);
    check("t5_rq",  hi_req,  32'd1);
    tick();
    check("t5_a1",  hi_addr, 32'hFFFF_FFFC);
    check("t5_p0",  hi_pc,   32'hFFFF_FFF8);
    check("t5_i0",  hi_inst, img(32'hFFFF_FFF8));
    tick();
    check("t5_a2",  hi_addr, 32'h0);
    check("t5_p1",  hi_pc,   32'hFFFF_FFFC);
    tick();
    check("t5_a3",  hi_addr, 32'h4);
    check("t5_p2",  hi_pc,   32'h0);

    // 6a: reset with three buffered entries and a request outstanding
    mem_lat = 1; Inst_Ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (Mem_Req && Mem_Addr == 32'hC) found = 1'b1;
      else tick();
    end
    check("t6_reachC", 32'(found), 32'd1);
    check("t6_v3",     Inst_Valid, 32'd1);
    check("t6_h0",     Inst_PC,    32'h0);
    Reset = 1'b1;
    tick();
    check("t6a_req",  Mem_Req,    32'd0);
    check("t6a_v",    Inst_Valid, 32'd0);
    check("t6a_inst", Inst,       32'd0);
    check("t6a_pc",   Inst_PC,    32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check("t6a_addr", Mem_Addr, 32'h0);
    check("t6a_rq",   Mem_Req,  32'd1);

    // 6b: reset while in DISCARD
    mem_lat = 3;
    tick();
    Redirect = 1'b1; Redirect_PC = 32'h40;
    tick();
    Redirect = 1'b0;
    check("t6b_dis_a", Mem_Addr, 32'h0);
    check("t6b_dis_r", Mem_Req,  32'd1);
    Reset = 1'b1;
    tick();
    check("t6b_req",  Mem_Req,    32'd0);
    check("t6b_v",    Inst_Valid, 32'd0);
    check("t6b_inst", Inst,       32'd0);
    check("t6b_pc",   Inst_PC,    32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check("t6b_addr", Mem_Addr, 32'h0);
    check("t6b_rq",   Mem_Req,  32'd1);
    Inst_Ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (Inst_Valid) found = 1'b1;
      else tick();
    end
    check("t6b_gotv", 32'(found), 32'd1);
    check("t6b_pc0",  Inst_PC,    32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
